// File: rtl/aes_slice_sequencer.sv
// ----------------------------------------------------------------------------
// aes_slice_sequencer
//
// Walks the AES result mux select through every 16-bit slice of the 128-bit
// result. Each slice is held for DWELL cycles. On the last cycle of the dwell
// the mux word is captured, and a one-cycle valid strobe flags the new word.
// A scan either runs once and ends with a done pulse, or loops until stopped.
//
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   synchronous active-low reset
//   start_i       in   pulse: begin a scan (only honoured in IDLE)
//   stop_i        in   abort the scan and return to IDLE
//   mode_loop_i   in   1 = continuous scanning, sampled when start is accepted
//   mux_data_i    in   AES mux output for the current select
//   sel_o         out  slice select to the AES mux
//   word_out_o    out  last captured slice word
//   word_idx_o    out  slice index of word_out_o
//   word_valid_o  out  one-cycle pulse when word_out_o/word_idx_o update
//   busy_o        out  high while scanning
//   done_o        out  one-cycle pulse at the end of a single scan
// ----------------------------------------------------------------------------
module aes_slice_sequencer #(
   parameter int DWELL      = 4,
   parameter int NUM_SLICES = 8,
   parameter int SEL_W      = 3,
   parameter int DATA_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              stop_i,
   input  logic              mode_loop_i,
   input  logic [DATA_W-1:0] mux_data_i,
   output logic [SEL_W-1:0]  sel_o,
   output logic [DATA_W-1:0] word_out_o,
   output logic [SEL_W-1:0]  word_idx_o,
   output logic              word_valid_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int                CNT_W      = $clog2(DWELL + 1);
   localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(DWELL - 1);
   localparam logic [SEL_W-1:0]  LAST_SEL   = SEL_W'(NUM_SLICES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   word_q, word_d;
   logic [SEL_W-1:0]    idx_q, idx_d;
   logic                valid_q, valid_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                loop_q, loop_d;

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sel_q   <= {SEL_W{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
         word_q  <= {DATA_W{1'b0}};
         idx_q   <= {SEL_W{1'b0}};
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         loop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         loop_q  <= loop_d;
      end
   end

   // Next-state and next-output logic for the IDLE/SCAN/DONE sequencer.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      idx_d   = idx_q;
      valid_d = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      loop_d  = loop_q;

      case (state_q)
         ST_IDLE: begin
            // A simultaneous stop cancels the start.
            if (start_i && !stop_i) begin
               state_d = ST_SCAN;
               sel_d   = {SEL_W{1'b0}};
               cnt_d   = CNT_RELOAD;
               loop_d  = mode_loop_i;
               busy_d  = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_SCAN: begin
            // Stop takes priority over a capture due on the same edge.
            if (stop_i) begin
               state_d = ST_IDLE;
               sel_d   = {SEL_W{1'b0}};
               cnt_d   = {CNT_W{1'b0}};
               busy_d  = 1'b0;
            end else if (cnt_q != {CNT_W{1'b0}}) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               word_d  = mux_data_i;
               idx_d   = sel_q;
               valid_d = 1'b1;
               cnt_d   = CNT_RELOAD;
               if (sel_q != LAST_SEL) begin
                  sel_d = sel_q + SEL_W'(1);
               end else if (loop_q) begin
                  sel_d = {SEL_W{1'b0}};
               end else begin
                  state_d = ST_DONE;
                  sel_d   = {SEL_W{1'b0}};
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end

         ST_DONE: begin
            // Single-cycle state; start is ignored here.
            state_d = ST_IDLE;
            sel_d   = {SEL_W{1'b0}};
            busy_d  = 1'b0;
         end

         default: begin
            state_d = ST_IDLE;
            sel_d   = {SEL_W{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
            busy_d  = 1'b0;
         end
      endcase
   end

   assign sel_o        = sel_q;
   assign word_out_o   = word_q;
   assign word_idx_o   = idx_q;
   assign word_valid_o = valid_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;

endmodule

// File: tb/tb_aes_slice_sequencer.sv
// ----------------------------------------------------------------------------
// tb_aes_slice_sequencer
//
// Two sequencers (DWELL=4 and DWELL=1) share the control inputs. Each one reads
// its own mux model, a slice table indexed by its select. A reference model
// counts the cycles since the scan started and derives the expected select,
// captures and done pulse arithmetically.
// ----------------------------------------------------------------------------
module tb_aes_slice_sequencer;

   localparam int NS = 8;

   logic        clk = 1'b0;
   logic        rst_n, start, stop, mode_loop;
   logic [15:0] tbl [NS];

   logic [2:0]  sel_a, idx_a, sel_b, idx_b;
   logic [15:0] mux_a, mux_b, word_a, word_b;
   logic        valid_a, busy_a, done_a, valid_b, busy_b, done_b;

   always #5 clk = ~clk;

   assign mux_a = tbl[sel_a];
   assign mux_b = tbl[sel_b];

   aes_slice_sequencer #(.DWELL(4), .NUM_SLICES(8), .SEL_W(3), .DATA_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .start_i(start), .stop_i(stop),
      .mode_loop_i(mode_loop), .mux_data_i(mux_a), .sel_o(sel_a),
      .word_out_o(word_a), .word_idx_o(idx_a), .word_valid_o(valid_a),
      .busy_o(busy_a), .done_o(done_a)
   );

   aes_slice_sequencer #(.DWELL(1), .NUM_SLICES(8), .SEL_W(3), .DATA_W(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .start_i(start), .stop_i(stop),
      .mode_loop_i(mode_loop), .mux_data_i(mux_b), .sel_o(sel_b),
      .word_out_o(word_b), .word_idx_o(idx_b), .word_valid_o(valid_b),
      .busy_o(busy_b), .done_o(done_b)
   );

   // Reference model state, index 0 -> dut_a (DWELL 4), 1 -> dut_b (DWELL 1)
   bit          m_act    [2];
   bit          m_loop   [2];
   bit          m_indone [2];
   int          m_t      [2];
   logic [2:0]  m_sel    [2];
   logic [2:0]  m_idx    [2];
   logic [15:0] m_word   [2];
   logic        m_valid  [2];
   logic        m_busy   [2];
   logic        m_done   [2];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   // Advance model i across one clock edge using the currently driven inputs.
   task automatic model_edge(input int i);
      int dw;
      int k;
      dw = (i == 0) ? 4 : 1;
      if (!rst_n) begin
         m_act[i] = 1'b0; m_loop[i] = 1'b0; m_indone[i] = 1'b0; m_t[i] = 0;
         m_sel[i] = 3'd0; m_idx[i] = 3'd0; m_word[i] = 16'h0000;
         m_valid[i] = 1'b0; m_busy[i] = 1'b0; m_done[i] = 1'b0;
      end else begin
         m_valid[i] = 1'b0;
         m_done[i]  = 1'b0;
         if (m_indone[i]) begin
            m_indone[i] = 1'b0;
         end else if (m_act[i]) begin
            if (stop) begin
               m_act[i] = 1'b0; m_sel[i] = 3'd0; m_busy[i] = 1'b0;
            end else begin
               m_t[i]++;
               if (m_t[i] % dw == 0) begin
                  k          = m_t[i] / dw - 1;
                  m_word[i]  = tbl[k % NS];
                  m_idx[i]   = 3'(k % NS);
                  m_valid[i] = 1'b1;
                  if (!m_loop[i] && m_t[i] == NS * dw) begin
                     m_act[i] = 1'b0; m_busy[i] = 1'b0; m_sel[i] = 3'd0;
                     m_indone[i] = 1'b1; m_done[i] = 1'b1;
                  end else begin
                     m_sel[i] = 3'((m_t[i] / dw) % NS);
                  end
               end
            end
         end else if (start && !stop) begin
            m_act[i] = 1'b1; m_t[i] = 0; m_loop[i] = mode_loop;
            m_sel[i] = 3'd0; m_busy[i] = 1'b1;
         end
      end
   endtask

   task automatic tick();
      model_edge(0);
      model_edge(1);
      @(posedge clk);
      #1;
      cyc++;
      check("a_sel",   {13'd0, sel_a},   {13'd0, m_sel[0]});
      check("a_word",  word_a,           m_word[0]);
      check("a_idx",   {13'd0, idx_a},   {13'd0, m_idx[0]});
      check("a_valid", {15'd0, valid_a}, {15'd0, m_valid[0]});
      check("a_busy",  {15'd0, busy_a},  {15'd0, m_busy[0]});
      check("a_done",  {15'd0, done_a},  {15'd0, m_done[0]});
      check("b_sel",   {13'd0, sel_b},   {13'd0, m_sel[1]});
      check("b_word",  word_b,           m_word[1]);
      check("b_idx",   {13'd0, idx_b},   {13'd0, m_idx[1]});
      check("b_valid", {15'd0, valid_b}, {15'd0, m_valid[1]});
      check("b_busy",  {15'd0, busy_b},  {15'd0, m_busy[1]});
      check("b_done",  {15'd0, done_b},  {15'd0, m_done[1]});
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode_loop = 1'b0;
      for (int k = 0; k < NS; k++) tbl[k] = 16'hA000 | 16'(k);

      // Reset held for two cycles
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Single scan with the A000|sel pattern
      start = 1'b1; mode_loop = 1'b0;
      tick();
      start = 1'b0;
      repeat (40) tick();

      // Loop scan with random slice words, then stop
      for (int k = 0; k < NS; k++) tbl[k] = 16'($urandom);
      start = 1'b1; mode_loop = 1'b1;
      tick();
      start = 1'b0; mode_loop = 1'b0;
      repeat (70) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      repeat (5) tick();

      // Stop mid-dwell while slice 3 is selected
      for (int k = 0; k < NS; k++) tbl[k] = 16'($urandom);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 50 && m_sel[0] != 3'd3; c++) tick();
      tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      repeat (12) tick();

      // Start while busy is ignored, then reset at slice 5
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      start = 1'b1; mode_loop = 1'b1;
      tick();
      start = 1'b0; mode_loop = 1'b0;
      for (int c = 0; c < 50 && m_sel[0] != 3'd5; c++) tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (40) tick();

      // Random control traffic
      for (int k = 0; k < NS; k++) tbl[k] = 16'($urandom);
      for (int c = 0; c < 400; c++) begin
         rst_n     = ($urandom_range(0, 99) != 0);
         start     = ($urandom_range(0, 7) == 0);
         stop      = ($urandom_range(0, 24) == 0);
         mode_loop = 1'($urandom_range(0, 1));
         tick();
      end
      rst_n = 1'b1; start = 1'b0; stop = 1'b0;
      repeat (40) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
